spi_flash_ctrl: RTL and testbench
=================================

SPI_FLASH_CTRL -- requirements
Module: spi_flash_ctrl

Interface
REQ-001 Parameter POLL_MAX, default 1000000: max status polls per PROGRAM/ERASE before error.
REQ-002 Parameter CW, default 20: poll counter width; SHALL hold POLL_MAX.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request pulse; accepted only when ready=1.
REQ-006 op  in  2  0 READ, 1 PROGRAM, 2 SECTOR_ERASE, 3 READ_ID.
REQ-007 addr  in  24  flash byte address.
REQ-008 wdata  in  8  PROGRAM data byte.
REQ-009 ready  out  1  idle, can accept start.
REQ-010 done  out  1  one-cycle pulse at operation end.
REQ-011 error  out  1  valid with done; poll timeout.
REQ-012 rdata  out  8  READ/READ_ID result, valid with done, held until next done.
REQ-013 cmd_trigger  out  1  to engine trigger.
REQ-014 cmd_busy  in  1  from engine busy.
REQ-015 cmd_in_count  out  9  bytes to send.
REQ-016 cmd_out_count  out  1  1 = read one byte after send.
REQ-017 cmd_data  out  40  send bytes LSB-aligned, first byte at [8*count-1 -: 8]; integrator zero-extends to engine width.
REQ-018 cmd_rdata  in  8  engine data_out.
REQ-019 cmd_quad  out  1  constant 0 (single-IO only).

Function
REQ-020 States: IDLE, WREN_ISSUE, WREN_WAIT, MAIN_ISSUE, MAIN_WAIT, POLL_ISSUE, POLL_WAIT, DONE.
REQ-021 IDLE: ready=1; start latches op/addr/wdata, ready falls next cycle; start while ready=0 ignored.
REQ-022 From IDLE: PROGRAM/ERASE -> WREN_ISSUE; READ/READ_ID -> MAIN_ISSUE.
REQ-023 *_ISSUE: cmd_trigger=1 and command fields stable until cmd_busy=1 sampled, then -> matching *_WAIT; trigger low in all other states.
REQ-024 *_WAIT: stay until cmd_busy=0; fields held stable throughout.
REQ-025 WREN: 1 byte 0x06, out_count 0; then -> MAIN_ISSUE.
REQ-026 MAIN: READ 0x03+addr[23:0], in_count 4, out_count 1; READ_ID 0x9F, in_count 1, out_count 1; PROGRAM 0x02+addr+wdata, in_count 5, out_count 0; ERASE 0x20+addr, in_count 4, out_count 0.
REQ-027 MAIN_WAIT exit: READ/READ_ID capture cmd_rdata into rdata -> DONE; PROGRAM/ERASE clear poll counter -> POLL_ISSUE.
REQ-028 POLL: 0x05, in_count 1, out_count 1; on POLL_WAIT exit increment counter; cmd_rdata[0]=0 -> DONE error=0; else counter==POLL_MAX -> DONE error=1; else -> POLL_ISSUE.
REQ-029 DONE: done=1 one cycle, then IDLE; ready=1 no earlier than cycle after done.
REQ-030 Engine busy=1 after its own reset: controller stays in *_ISSUE with trigger high until busy cycles; no lost command.
REQ-031 rdata unchanged by PROGRAM/ERASE.

Reset
REQ-032 reset_n low asynchronously forces IDLE; ready=1, done=0, error=0, rdata=0, cmd_trigger=0, cmd_in_count=0, cmd_out_count=0, cmd_data=0, poll counter=0.
REQ-033 Reset mid-operation abandons it with no done pulse; in-flight engine transfer not tracked.

Structure
REQ-034 Shared package: op encodings, flash opcodes (0x03, 0x02, 0x20, 0x06, 0x05, 0x9F), state encoding.
REQ-035 Single module, no sub-modules; spi_cmd instantiated by integrator.

Verification (bench uses behavioural engine model: busy rises 1 cycle after trigger, stays N*8+8 cycles)
REQ-036 READ addr=0x012345, model returns 0xA5 -> one cmd 0x03012345 in_count 4; done, rdata=0xA5, error=0.
REQ-037 PROGRAM addr=0x000100 wdata=0x3C, status 0x01,0x01,0x00 -> 0x06, 0x020001003C, three 0x05; done error=0.
REQ-038 ERASE with POLL_MAX=4, status stuck 0x01 -> exactly 4 polls; done error=1.
REQ-039 READ_ID, model returns 0xEF -> cmd 0x9F in_count 1; rdata=0xEF.
REQ-040 start held during PROGRAM -> no extra ops; reset_n low during POLL_WAIT -> ready=1 immediately, no done.
REQ-041 Engine held busy 20 cycles after reset, start READ at cycle 2 -> trigger held until busy seen, one command issued.

Source files
------------

// File: rtl/spi_flash_ctrl_pkg.sv
// Shared encodings for the SPI flash command sequencer: host op codes,
// flash opcodes, FSM states and the command record handed to the engine.
package spi_flash_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2,
    OP_READ_ID = 2'd3
  } op_e;

  localparam logic [7:0] FL_READ = 8'h03;
  localparam logic [7:0] FL_PP   = 8'h02;
  localparam logic [7:0] FL_SE   = 8'h20;
  localparam logic [7:0] FL_WREN = 8'h06;
  localparam logic [7:0] FL_RDSR = 8'h05;
  localparam logic [7:0] FL_RDID = 8'h9F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREN_ISSUE,
    ST_WREN_WAIT,
    ST_MAIN_ISSUE,
    ST_MAIN_WAIT,
    ST_POLL_ISSUE,
    ST_POLL_WAIT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [8:0]  in_count;
    logic        out_count;
    logic [39:0] data;
  } cmd_t;

  // Main command bytes, LSB-aligned with the opcode as the most significant byte sent.
  function automatic cmd_t main_cmd(op_e op, logic [23:0] addr, logic [7:0] wdata);
    cmd_t c;
    c = '0;
    case (op)
      OP_READ: begin
        c.in_count  = 9'd4;
        c.out_count = 1'b1;
        c.data      = {8'd0, FL_READ, addr};
      end
      OP_PROGRAM: begin
        c.in_count  = 9'd5;
        c.data      = {FL_PP, addr, wdata};
      end
      OP_ERASE: begin
        c.in_count  = 9'd4;
        c.data      = {8'd0, FL_SE, addr};
      end
      default: begin
        c.in_count  = 9'd1;
        c.out_count = 1'b1;
        c.data      = {32'd0, FL_RDID};
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/spi_flash_ctrl_if.sv
// Host request/response and SPI command-engine signals of the flash controller.
interface spi_flash_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [23:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic        done;
  logic        error;
  logic [7:0]  rdata;

  logic        cmd_trigger;
  logic        cmd_busy;
  logic [8:0]  cmd_in_count;
  logic        cmd_out_count;
  logic [39:0] cmd_data;
  logic [7:0]  cmd_rdata;
  logic        cmd_quad;

  modport slave (
    input  start, op, addr, wdata, cmd_busy, cmd_rdata,
    output ready, done, error, rdata,
           cmd_trigger, cmd_in_count, cmd_out_count, cmd_data, cmd_quad
  );

  modport master (
    output start, op, addr, wdata, cmd_busy, cmd_rdata,
    input  ready, done, error, rdata,
           cmd_trigger, cmd_in_count, cmd_out_count, cmd_data, cmd_quad
  );
endinterface

// File: rtl/spi_flash_ctrl.sv
// SPI flash operation sequencer: turns READ/PROGRAM/ERASE/READ_ID requests into
// WREN / main / status-poll commands for an external single-IO SPI command engine.
module spi_flash_ctrl
  import spi_flash_ctrl_pkg::*;
#(
  parameter int POLL_MAX = 1000000,
  parameter int CW       = 20
) (
  input logic             clk,
  input logic             reset_n,
  spi_flash_ctrl_if.slave bus
);

  localparam logic [CW-1:0] POLL_LIM = CW'(POLL_MAX);

  state_e        r_state, w_next;
  op_e           r_op;
  logic [23:0]   r_addr;
  logic [7:0]    r_wdata;
  logic [7:0]    r_rdata;
  logic          r_err;
  logic [CW-1:0] r_poll_cnt;
  logic          r_busy_low;
  logic [CW-1:0] w_poll_inc;
  logic          w_is_read;
  logic          w_go;
  logic          w_timeout;
  cmd_t          w_cmd;

  assign w_poll_inc = r_poll_cnt + CW'(1);
  assign w_is_read  = (r_op == OP_READ) || (r_op == OP_READ_ID);
  assign w_timeout  = (w_poll_inc == POLL_LIM);
  // Busy must be seen low in this issue state before a high counts as acceptance,
  // so an engine still busy from its own reset cannot swallow the trigger.
  assign w_go       = bus.cmd_busy && r_busy_low;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:
        if (bus.start)
          w_next = (op_e'(bus.op) == OP_PROGRAM || op_e'(bus.op) == OP_ERASE)
                   ? ST_WREN_ISSUE : ST_MAIN_ISSUE;
      ST_WREN_ISSUE: if (w_go)          w_next = ST_WREN_WAIT;
      ST_WREN_WAIT:  if (!bus.cmd_busy) w_next = ST_MAIN_ISSUE;
      ST_MAIN_ISSUE: if (w_go)          w_next = ST_MAIN_WAIT;
      ST_MAIN_WAIT:  if (!bus.cmd_busy) w_next = w_is_read ? ST_DONE : ST_POLL_ISSUE;
      ST_POLL_ISSUE: if (w_go)          w_next = ST_POLL_WAIT;
      ST_POLL_WAIT:
        if (!bus.cmd_busy)
          w_next = (!bus.cmd_rdata[0] || w_timeout) ? ST_DONE : ST_POLL_ISSUE;
      ST_DONE:       w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cmd = '0;
    case (r_state)
      ST_WREN_ISSUE, ST_WREN_WAIT: begin
        w_cmd.in_count = 9'd1;
        w_cmd.data     = {32'd0, FL_WREN};
      end
      ST_MAIN_ISSUE, ST_MAIN_WAIT: w_cmd = main_cmd(r_op, r_addr, r_wdata);
      ST_POLL_ISSUE, ST_POLL_WAIT: begin
        w_cmd.in_count  = 9'd1;
        w_cmd.out_count = 1'b1;
        w_cmd.data      = {32'd0, FL_RDSR};
      end
      default: w_cmd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op       <= OP_READ;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_poll_cnt <= '0;
      r_busy_low <= 1'b0;
    end else begin
      r_busy_low <= (w_next == r_state) && (r_busy_low || !bus.cmd_busy);
      case (r_state)
        ST_IDLE:
          if (bus.start) begin
            r_op    <= op_e'(bus.op);
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_err   <= 1'b0;
          end
        ST_MAIN_WAIT:
          if (!bus.cmd_busy) begin
            if (w_is_read) r_rdata    <= bus.cmd_rdata;
            else           r_poll_cnt <= '0;
          end
        ST_POLL_WAIT:
          if (!bus.cmd_busy) begin
            r_poll_cnt <= w_poll_inc;
            r_err      <= bus.cmd_rdata[0] && w_timeout;
          end
        default: ;
      endcase
    end
  end

  assign bus.ready         = (r_state == ST_IDLE);
  assign bus.done          = (r_state == ST_DONE);
  assign bus.error         = r_err;
  assign bus.rdata         = r_rdata;
  assign bus.cmd_trigger   = (r_state == ST_WREN_ISSUE) || (r_state == ST_MAIN_ISSUE) ||
                             (r_state == ST_POLL_ISSUE);
  assign bus.cmd_in_count  = w_cmd.in_count;
  assign bus.cmd_out_count = w_cmd.out_count;
  assign bus.cmd_data      = w_cmd.data;
  assign bus.cmd_quad      = 1'b0;

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Bench for spi_flash_ctrl: behavioural SPI engine, table vectors, random ops
// against a command-list model, and reset / busy-after-reset corner cases.
`timescale 1ns/1ps
module tb_spi_flash_ctrl;
  localparam int PMAX = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  spi_flash_ctrl_if bus();
  spi_flash_ctrl #(.POLL_MAX(PMAX), .CW(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  typedef struct { int n; int rd; logic [39:0] d; } ecmd_t;

  // Engine model: accepts trigger when idle, busy from next cycle for n*8+8 cycles.
  ecmd_t      log_q[$];
  int         cyc = 0, eng_cnt = 0, hold_until = 0, poll_cnt = 0;
  int         poll_base = 0, busy_polls = 0;
  logic [7:0] rd_byte = 8'h00, eng_rdata = 8'h00;

  assign bus.cmd_busy  = (cyc < hold_until) || (eng_cnt > 0);
  assign bus.cmd_rdata = eng_rdata;

  always @(posedge clk) begin : engine
    ecmd_t      c;
    logic [7:0] first;
    cyc <= cyc + 1;
    if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
    else if (!bus.cmd_busy && bus.cmd_trigger) begin
      c.n   = int'(bus.cmd_in_count);
      c.rd  = int'(bus.cmd_out_count);
      c.d   = bus.cmd_data;
      first = (c.n > 0) ? 8'(bus.cmd_data >> (8 * (c.n - 1))) : 8'h00;
      if (first == 8'h05) begin
        eng_rdata <= ((poll_cnt - poll_base) < busy_polls) ? 8'h01 : 8'h00;
        poll_cnt  <= poll_cnt + 1;
      end else if (first == 8'h03 || first == 8'h9F) eng_rdata <= rd_byte;
      else eng_rdata <= 8'h5A;
      eng_cnt <= c.n * 8 + 8;
      log_q.push_back(c);
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: expected command list and result from the op rules.
  ecmd_t      exp_q[$];
  bit         m_err;
  logic [7:0] m_rdata = 8'h00;

  task automatic build_exp(input logic [1:0] op, input logic [23:0] a, input logic [7:0] wd,
                           input logic [7:0] rd, input int k);
    int np;
    exp_q.delete();
    m_err = 1'b0;
    if (op == 2'd1 || op == 2'd2) exp_q.push_back('{1, 0, 40'h06});
    case (op)
      2'd0: exp_q.push_back('{4, 1, 40'h0003000000 | {16'd0, a}});
      2'd1: exp_q.push_back('{5, 0, {8'h02, a, wd}});
      2'd2: exp_q.push_back('{4, 0, 40'h0020000000 | {16'd0, a}});
      default: exp_q.push_back('{1, 1, 40'h9F});
    endcase
    if (op == 2'd1 || op == 2'd2) begin
      np = (k < PMAX) ? k + 1 : PMAX;
      for (int i = 0; i < np; i++) exp_q.push_back('{1, 1, 40'h05});
      m_err = (k >= PMAX);
    end else m_rdata = rd;
  endtask

  task automatic wait_done(input string tag, output bit got);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (bus.done) got = 1'b1;
      else @(negedge clk);
    end
    bus.start = 1'b0;
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [23:0] a,
                        input logic [7:0] wd, input logic [7:0] rd, input int k,
                        input bit hold, output int base, output bit got);
    rd_byte = rd; busy_polls = k; poll_base = poll_cnt;
    base = log_q.size();
    @(negedge clk);
    bus.op = op; bus.addr = a; bus.wdata = wd; bus.start = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    chk({tag, "_ready_fall"}, 64'(bus.ready), 64'd0);
    wait_done(tag, got);
  endtask

  task automatic verify(input string tag, input int base, input bit got);
    chk({tag, "_err"}, 64'(bus.error), 64'(m_err));
    chk({tag, "_rdata"}, 64'(bus.rdata), 64'(m_rdata));
    chk({tag, "_ncmd"}, 64'(log_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < log_q.size()) begin
        chk($sformatf("%s_cmd%0d_data", tag, i), log_q[base+i].d, exp_q[i].d);
        chk($sformatf("%s_cmd%0d_n", tag, i), 64'(log_q[base+i].n), 64'(exp_q[i].n));
        chk($sformatf("%s_cmd%0d_rd", tag, i), 64'(log_q[base+i].rd), 64'(exp_q[i].rd));
      end
    if (got) begin
      chk({tag, "_ready_in_done"}, 64'(bus.ready), 64'd0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      chk({tag, "_ready_after"}, 64'(bus.ready), 64'd1);
    end
  endtask

  typedef struct {
    logic [1:0] op; logic [23:0] a; logic [7:0] wd; logic [7:0] rd;
    int k; int ncmd; bit err; logic [7:0] rdata;
  } vec_t;
  vec_t tv[6];

  initial begin
    int  base, dcnt;
    bit  got;
    logic [1:0] rop;

    tv[0] = '{2'd0, 24'h012345, 8'h00, 8'hA5, 0,   1, 1'b0, 8'hA5};
    tv[1] = '{2'd1, 24'h000100, 8'h3C, 8'h11, 2,   5, 1'b0, 8'hA5};
    tv[2] = '{2'd2, 24'h00ABCD, 8'h00, 8'h11, 100, 6, 1'b1, 8'hA5};
    tv[3] = '{2'd3, 24'h000000, 8'h00, 8'hEF, 0,   1, 1'b0, 8'hEF};
    tv[4] = '{2'd1, 24'hFFFFFF, 8'hFF, 8'h22, 0,   3, 1'b0, 8'hEF};
    tv[5] = '{2'd2, 24'h800000, 8'h00, 8'h22, 3,   6, 1'b0, 8'hEF};

    bus.start = 1'b0; bus.op = 2'd0; bus.addr = '0; bus.wdata = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_trigger", 64'(bus.cmd_trigger), 64'd0);
    chk("rst_in_count", 64'(bus.cmd_in_count), 64'd0);
    chk("rst_out_count", 64'(bus.cmd_out_count), 64'd0);
    chk("rst_data", 64'(bus.cmd_data), 64'd0);
    chk("rst_quad", 64'(bus.cmd_quad), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      build_exp(tv[i].op, tv[i].a, tv[i].wd, tv[i].rd, tv[i].k);
      run_op($sformatf("tv%0d", i), tv[i].op, tv[i].a, tv[i].wd, tv[i].rd, tv[i].k, 1'b0, base, got);
      chk($sformatf("tv%0d_tbl_ncmd", i), 64'(log_q.size() - base), 64'(tv[i].ncmd));
      chk($sformatf("tv%0d_tbl_err", i), 64'(bus.error), 64'(tv[i].err));
      chk($sformatf("tv%0d_tbl_rdata", i), 64'(bus.rdata), 64'(tv[i].rdata));
      verify($sformatf("tv%0d", i), base, got);
    end

    for (int i = 0; i < 25; i++) begin
      logic [23:0] a;
      logic [7:0]  wd, rd;
      int          k;
      rop = 2'($urandom_range(0, 3));
      a = 24'($urandom); wd = 8'($urandom); rd = 8'($urandom);
      k = $urandom_range(0, 5);
      build_exp(rop, a, wd, rd, k);
      run_op($sformatf("rnd%0d", i), rop, a, wd, rd, k, 1'b0, base, got);
      verify($sformatf("rnd%0d", i), base, got);
    end

    // start held high for a whole PROGRAM: only one operation may run
    build_exp(2'd1, 24'h0000AA, 8'h55, 8'h00, 1);
    run_op("hold", 2'd1, 24'h0000AA, 8'h55, 8'h00, 1, 1'b1, base, got);
    verify("hold", base, got);
    repeat (40) @(negedge clk);
    chk("hold_no_extra", 64'(log_q.size() - base), 64'(exp_q.size()));
    chk("hold_ready_idle", 64'(bus.ready), 64'd1);

    // reset asserted while a status poll is in flight
    busy_polls = 100; poll_base = poll_cnt; base = log_q.size();
    @(negedge clk);
    bus.op = 2'd1; bus.addr = 24'h001000; bus.wdata = 8'h77; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (log_q.size() - base >= 3) got = 1'b1;
    end
    chk("rstmid_poll_seen", 64'(got), 64'd1);
    repeat (3) @(negedge clk);
    chk("rstmid_in_wait", 64'(bus.cmd_trigger), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("rstmid_ready", 64'(bus.ready), 64'd1);
    chk("rstmid_done", 64'(bus.done), 64'd0);
    chk("rstmid_rdata", 64'(bus.rdata), 64'd0);
    m_rdata = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("rstmid_no_done", 64'(dcnt), 64'd0);

    // engine busy for 20 cycles after reset, READ requested at cycle 2
    reset_n = 1'b0;
    @(negedge clk);
    hold_until = cyc + 20;
    reset_n = 1'b1;
    base = log_q.size();
    rd_byte = 8'hC3;
    build_exp(2'd0, 24'hABCDEF, 8'h00, 8'hC3, 0);
    repeat (2) @(negedge clk);
    bus.op = 2'd0; bus.addr = 24'hABCDEF; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("hold_trig_high", 64'(bus.cmd_trigger), 64'd1);
    chk("hold_no_cmd_yet", 64'(log_q.size() - base), 64'd0);
    wait_done("bsyrst", got);
    verify("bsyrst", base, got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
